// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Brief    : Control bundle between the multi-cycle MIPS control FSM (master)
//            and the datapath (slave): instruction fields in, enables out.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [1:0] PCSource;
  logic [3:0] ALU_control;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  // Control FSM side
  modport master (
    input  opcode, funct, Zero,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSource, ALU_control,
           instr_done, illegal, state
  );

  // Datapath side
  modport slave (
    output opcode, funct, Zero,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSource, ALU_control,
           instr_done, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore control FSM for the multi-cycle MIPS datapath. Sequences
//            fetch/decode/execute/memory/writeback and drives the ALU code
//            and all datapath enables.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_OR  = 4'b0001
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_control_if.master bus
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_ori   = 6'b001101;

  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_sub   = 6'b100010;
  localparam logic [5:0] c_fn_or    = 6'b100101;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEMADR   = 4'd3,
    ST_MEMRD    = 4'd4,
    ST_MEMWB    = 4'd5,
    ST_MEMWR    = 4'd6,
    ST_RTYPE_EX = 4'd7,
    ST_RTYPE_WB = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_IMM_EX   = 4'd11,
    ST_IMM_WB   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  assign bus.state = r_state;

  // State register; reset is asynchronous so strobes drop the instant rst rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs (funct/opcode/Zero refine a few states)
  always_comb begin
    w_next          = ST_IDLE;
    bus.PCWrite     = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ZeroExt     = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALU_control = 4'b0000;
    bus.instr_done  = 1'b0;
    bus.illegal     = 1'b0;

    case (r_state)
      ST_IDLE: w_next = ST_FETCH;

      ST_FETCH: begin
        bus.MemRead     = 1'b1;
        bus.IRWrite     = 1'b1;
        bus.ALUSrcB     = 2'b01;
        bus.ALU_control = ALU_ADD;
        bus.PCWrite     = 1'b1;
        w_next          = ST_DECODE;
      end

      // Branch target is precomputed here while the opcode is decoded
      ST_DECODE: begin
        bus.ALUSrcB     = 2'b11;
        bus.ALU_control = ALU_ADD;
        case (bus.opcode)
          c_op_lw, c_op_sw:    w_next = ST_MEMADR;
          c_op_rtype:          w_next = ST_RTYPE_EX;
          c_op_beq:            w_next = ST_BRANCH;
          c_op_j:              w_next = ST_JUMP;
          c_op_addi, c_op_ori: w_next = ST_IMM_EX;
          default: begin
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
            w_next         = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 2'b10;
        bus.ALU_control = ALU_ADD;
        w_next          = (bus.opcode == c_op_lw) ? ST_MEMRD : ST_MEMWR;
      end

      ST_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        w_next      = ST_MEMWB;
      end

      ST_MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = ST_FETCH;
      end

      ST_MEMWR: begin
        bus.MemWrite   = 1'b1;
        bus.IorD       = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = ST_FETCH;
      end

      // Unsupported funct retires here without touching the register file
      ST_RTYPE_EX: begin
        bus.ALUSrcA = 1'b1;
        w_next      = ST_RTYPE_WB;
        case (bus.funct)
          c_fn_add: bus.ALU_control = ALU_ADD;
          c_fn_sub: bus.ALU_control = ALU_SUB;
          c_fn_or:  bus.ALU_control = ALU_OR;
          default: begin
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
            w_next         = ST_FETCH;
          end
        endcase
      end

      ST_RTYPE_WB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = ST_FETCH;
      end

      ST_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALU_control = ALU_SUB;
        bus.PCSource    = 2'b01;
        bus.PCWrite     = bus.Zero;
        bus.instr_done  = 1'b1;
        w_next          = ST_FETCH;
      end

      ST_JUMP: begin
        bus.PCSource   = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = ST_FETCH;
      end

      ST_IMM_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        if (bus.opcode == c_op_ori) begin
          bus.ALU_control = ALU_OR;
          bus.ZeroExt     = 1'b1;
        end else begin
          bus.ALU_control = ALU_ADD;
        end
        w_next = ST_IMM_WB;
      end

      ST_IMM_WB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = ST_FETCH;
      end

      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control: instruction table
//            with a per-cycle expected-state/output scoreboard, plus reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic clk;
  logic rst;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic       zext;
    logic [1:0] pcsrc;
    logic [3:0] alu;
    logic       done;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         n;
    logic [3:0] st [5];
  } vec_t;

  typedef struct {
    int         vec;
    int         cyc;
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  exp_t sb_q [$];
  int checks   = 0;
  int failures = 0;

  // Expected outputs of each state, written from the state table
  function automatic ctl_t model(input logic [3:0] st, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z);
    ctl_t c;
    c = '0;
    case (st)
      4'd1: begin c.mrd = 1; c.irw = 1; c.srcb = 2'b01; c.alu = 4'b0010; c.pcw = 1; end
      4'd2: begin
        c.srcb = 2'b11; c.alu = 4'b0010;
        if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b000010, 6'b001000, 6'b001101})) begin
          c.ill = 1; c.done = 1;
        end
      end
      4'd3: begin c.srca = 1; c.srcb = 2'b10; c.alu = 4'b0010; end
      4'd4: begin c.mrd = 1; c.iord = 1; end
      4'd5: begin c.rw = 1; c.m2r = 1; c.done = 1; end
      4'd6: begin c.mwr = 1; c.iord = 1; c.done = 1; end
      4'd7: begin
        c.srca = 1;
        if (fn == 6'b100000)      c.alu = 4'b0010;
        else if (fn == 6'b100010) c.alu = 4'b0110;
        else if (fn == 6'b100101) c.alu = 4'b0001;
        else begin c.ill = 1; c.done = 1; end
      end
      4'd8:  begin c.rw = 1; c.rdst = 1; c.done = 1; end
      4'd9:  begin c.srca = 1; c.alu = 4'b0110; c.pcsrc = 2'b01; c.pcw = z; c.done = 1; end
      4'd10: begin c.pcsrc = 2'b10; c.pcw = 1; c.done = 1; end
      4'd11: begin
        c.srca = 1; c.srcb = 2'b10;
        if (op == 6'b001101) begin c.alu = 4'b0001; c.zext = 1; end
        else c.alu = 4'b0010;
      end
      4'd12: begin c.rw = 1; c.done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.pcw   = bus.PCWrite;
    c.iord  = bus.IorD;
    c.mrd   = bus.MemRead;
    c.mwr   = bus.MemWrite;
    c.irw   = bus.IRWrite;
    c.m2r   = bus.MemtoReg;
    c.rdst  = bus.RegDst;
    c.rw    = bus.RegWrite;
    c.srca  = bus.ALUSrcA;
    c.srcb  = bus.ALUSrcB;
    c.zext  = bus.ZeroExt;
    c.pcsrc = bus.PCSource;
    c.alu   = bus.ALU_control;
    c.done  = bus.instr_done;
    c.ill   = bus.illegal;
    return c;
  endfunction

  task automatic check_st(input string name, input logic [3:0] exp_st);
    checks++;
    if (bus.state !== exp_st) begin
      failures++;
      $display("FAIL %s: state got %0d expected %0d", name, bus.state, exp_st);
    end
  endtask

  task automatic check_ctl(input string name, input ctl_t exp_c);
    ctl_t got;
    got = sample();
    checks++;
    if (got !== exp_c) begin
      failures++;
      $display("FAIL %s: outputs got %05h expected %05h", name, got, exp_c);
    end
  endtask

  // Pops one expected cycle record and compares it to the DUT
  task automatic pop_and_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: queue empty got 0 entries required >=1");
    end else begin
      e = sb_q.pop_front();
      check_st($sformatf("vec%0d cyc%0d", e.vec, e.cyc), e.st);
      check_ctl($sformatf("vec%0d cyc%0d", e.vec, e.cyc), e.ctl);
    end
  endtask

  vec_t vecs [12];
  ctl_t c_fetch;

  initial begin
    //           op         fn         z   n  states
    vecs[0]  = '{6'b100011, 6'b000000, 0, 5, '{1, 2, 3, 4, 5}};  // lw
    vecs[1]  = '{6'b101011, 6'b000000, 0, 4, '{1, 2, 3, 6, 0}};  // sw
    vecs[2]  = '{6'b000000, 6'b100000, 0, 4, '{1, 2, 7, 8, 0}};  // add
    vecs[3]  = '{6'b000000, 6'b100010, 0, 4, '{1, 2, 7, 8, 0}};  // sub
    vecs[4]  = '{6'b000000, 6'b100101, 0, 4, '{1, 2, 7, 8, 0}};  // or
    vecs[5]  = '{6'b000100, 6'b000000, 1, 3, '{1, 2, 9, 0, 0}};  // beq taken
    vecs[6]  = '{6'b000100, 6'b000000, 0, 3, '{1, 2, 9, 0, 0}};  // beq not taken
    vecs[7]  = '{6'b000010, 6'b000000, 0, 3, '{1, 2, 10, 0, 0}}; // j
    vecs[8]  = '{6'b001000, 6'b000000, 0, 4, '{1, 2, 11, 12, 0}}; // addi
    vecs[9]  = '{6'b001101, 6'b000000, 0, 4, '{1, 2, 11, 12, 0}}; // ori
    vecs[10] = '{6'b111111, 6'b000000, 0, 2, '{1, 2, 0, 0, 0}};  // illegal opcode
    vecs[11] = '{6'b000000, 6'b000000, 0, 3, '{1, 2, 7, 0, 0}};  // illegal funct

    c_fetch      = '0;
    c_fetch.mrd  = 1;
    c_fetch.irw  = 1;
    c_fetch.pcw  = 1;
    c_fetch.srcb = 2'b01;
    c_fetch.alu  = 4'b0010;

    bus.opcode = 6'b0;
    bus.funct  = 6'b0;
    bus.Zero   = 1'b0;
    rst        = 1'b1;

    // Reset held for three cycles: IDLE with everything low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_st("reset state", 4'd0);
      check_ctl("reset outputs", '0);
    end
    rst = 1'b0;
    @(posedge clk);

    // Back-to-back instructions; each starts with the DUT in FETCH
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      bus.opcode = vecs[v].op;
      bus.funct  = vecs[v].fn;
      bus.Zero   = vecs[v].z;
      for (int c = 0; c < vecs[v].n; c++) begin
        exp_t e;
        e.vec = v;
        e.cyc = c;
        e.st  = vecs[v].st[c];
        e.ctl = model(vecs[v].st[c], vecs[v].op, vecs[v].fn, vecs[v].z);
        sb_q.push_back(e);
      end
      #1;
      for (int c = 0; c < vecs[v].n; c++) begin
        if (c > 0) @(negedge clk);
        pop_and_check();
      end
    end

    // Every instruction returns to FETCH
    @(negedge clk);
    check_st("return to fetch", 4'd1);
    check_ctl("fetch outputs", c_fetch);

    // Reset in the middle of sw, while MemWrite is asserted
    bus.opcode = 6'b101011;
    bus.funct  = 6'b000000;
    bus.Zero   = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge clk);
    check_st("sw reaches MEMWR", 4'd6);
    checks++;
    if (bus.MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL memwr strobe: MemWrite got %b expected 1", bus.MemWrite);
    end
    #1 rst = 1'b1;
    #1;
    check_st("async reset state", 4'd0);
    checks++;
    if (bus.MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL async reset MemWrite: got %b expected 0", bus.MemWrite);
    end
    check_ctl("async reset outputs", '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_st("held reset state", 4'd0);
      check_ctl("held reset outputs", '0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_st("fetch after reset", 4'd1);
    check_ctl("fetch after reset outputs", c_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
